// File: rtl/tmds_serializer_pkg.sv
// ---------------------------------------------------------------------------
// tmds_serializer_pkg
//
// Shared HDMI/TMDS constants used by the serializer and its lane registers:
// the symbol width, the four TMDS control symbols, the 10-bit TMDS clock
// pattern (sent LSB first), and the bit-counter type that walks one symbol.
// ---------------------------------------------------------------------------
package tmds_serializer_pkg;

    localparam int TMDS_SYM_W = 10;

    // Control symbols for C1:C0 = 00, 01, 10, 11.
    localparam logic [TMDS_SYM_W-1:0] CTL0 = 10'b1101010100;
    localparam logic [TMDS_SYM_W-1:0] CTL1 = 10'b0010101011;
    localparam logic [TMDS_SYM_W-1:0] CTL2 = 10'b0101010100;
    localparam logic [TMDS_SYM_W-1:0] CTL3 = 10'b1010101011;

    // Clock lane pattern: five ones on bits 0..4, five zeros on bits 5..9.
    localparam logic [TMDS_SYM_W-1:0] TMDS_CLK_PATTERN = 10'b0000011111;

    // Position of the bit currently on the serial outputs (0..9).
    typedef logic [3:0] bit_cnt_t;

    localparam bit_cnt_t BIT_CNT_FIRST = 4'd0;
    localparam bit_cnt_t BIT_CNT_LAST  = 4'd9;

    // Level of the TMDS clock lane while bit 'cnt' of a symbol is shown.
    function automatic logic clk_level(input bit_cnt_t cnt);
        return TMDS_CLK_PATTERN[cnt];
    endfunction

endpackage

// File: rtl/tmds_serializer_shift_lane.sv
// ---------------------------------------------------------------------------
// tmds_shift_lane
//
// One TMDS lane: a symbol-wide register that either loads a new symbol or
// shifts right by one bit each clock. The LSB is the serial output, so a
// symbol is sent LSB first.
//
// Ports
//   clk_i   bit clock
//   rst_i   synchronous active-high reset (register cleared to 0)
//   load_i  load sym_i this cycle instead of shifting
//   sym_i   symbol to load
//   bit_o   serial bit currently being transmitted
// ---------------------------------------------------------------------------
module tmds_shift_lane
    import tmds_serializer_pkg::*;
#(
    parameter int SYM_W = TMDS_SYM_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [SYM_W-1:0] sym_i,
    output logic             bit_o
);

    logic [SYM_W-1:0] shreg_q;
    logic [SYM_W-1:0] shreg_d;

    always_comb begin
        if (load_i) begin
            shreg_d = sym_i;
        end else begin
            shreg_d = shreg_q >> 1;
        end
    end

    // The output buffer must see a defined level out of reset, so the
    // shift register is cleared along with the control state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign bit_o = shreg_q[0];

endmodule

// File: rtl/tmds_serializer.sv
// ---------------------------------------------------------------------------
// tmds_serializer
//
// Serializes groups of CHANNELS parallel 10-bit TMDS symbols into one serial
// bit stream per lane, running in the bit-clock domain (10x pixel clock).
// A one-deep holding register decouples the producer from the symbol
// boundary. Every 10 clocks the holding register is moved into the lane
// shift registers; if it is empty, IDLE_SYM is sent instead and 'underflow'
// pulses. The output stream never pauses.
//
// Ports
//   clk            bit clock
//   rst            synchronous active-high reset
//   s_valid        s_data holds a valid symbol group
//   s_ready        symbol group is accepted this cycle (combinational)
//   s_data         lane n in bits [n*SYM_W +: SYM_W]
//   ser_out        serial data per lane, LSB of each symbol first
//   ser_clk        TMDS clock pattern aligned with ser_out
//   sym_start      high while bit 0 of a symbol is on ser_out
//   underflow      one-cycle pulse when IDLE_SYM replaced missing data
//   underflow_seen sticky copy of underflow, cleared only by rst
// ---------------------------------------------------------------------------
module tmds_serializer
    import tmds_serializer_pkg::*;
#(
    parameter int                CHANNELS = 3,
    parameter int                SYM_W    = TMDS_SYM_W,
    parameter logic [SYM_W-1:0]  IDLE_SYM = CTL0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [CHANNELS*SYM_W-1:0] s_data,
    output logic [CHANNELS-1:0]       ser_out,
    output logic                      ser_clk,
    output logic                      sym_start,
    output logic                      underflow,
    output logic                      underflow_seen
);

    localparam int GRP_W = CHANNELS * SYM_W;

    bit_cnt_t         bit_cnt_q;
    bit_cnt_t         bit_cnt_d;
    logic             hold_v_q;
    logic             hold_v_d;
    logic [GRP_W-1:0] hold_q;
    logic [GRP_W-1:0] hold_d;
    logic             ser_clk_q;
    logic             ser_clk_d;
    logic             sym_start_q;
    logic             sym_start_d;
    logic             underflow_q;
    logic             underflow_d;
    logic             underflow_seen_q;
    logic             underflow_seen_d;

    logic             load;
    logic             xfer;
    logic [GRP_W-1:0] load_data;

    // The last bit of a symbol is on the wire: the lanes reload on this edge.
    assign load = (bit_cnt_q == BIT_CNT_LAST);

    // Ready is combinational so the holding register can be emptied into the
    // lanes and refilled by the producer on the same edge.
    assign s_ready = !rst && (!hold_v_q || load);
    assign xfer    = s_valid && s_ready;

    always_comb begin
        bit_cnt_d = load ? BIT_CNT_FIRST : bit_cnt_q + 4'd1;

        hold_d = xfer ? s_data : hold_q;

        // On a load the old contents leave the holding register; it stays
        // occupied only if a new group arrives on the same edge.
        if (load) begin
            hold_v_d = xfer;
        end else begin
            hold_v_d = hold_v_q | xfer;
        end

        load_data = hold_v_q ? hold_q : {CHANNELS{IDLE_SYM}};

        // Status outputs are registered from the next bit position so they
        // line up with the bit the lanes present after the same edge.
        ser_clk_d        = clk_level(bit_cnt_d);
        sym_start_d      = (bit_cnt_d == BIT_CNT_FIRST);
        underflow_d      = load && !hold_v_q;
        underflow_seen_d = underflow_seen_q | underflow_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q        <= BIT_CNT_LAST;
            hold_v_q         <= 1'b0;
            ser_clk_q        <= 1'b0;
            sym_start_q      <= 1'b0;
            underflow_q      <= 1'b0;
            underflow_seen_q <= 1'b0;
        end else begin
            bit_cnt_q        <= bit_cnt_d;
            hold_v_q         <= hold_v_d;
            ser_clk_q        <= ser_clk_d;
            sym_start_q      <= sym_start_d;
            underflow_q      <= underflow_d;
            underflow_seen_q <= underflow_seen_d;
        end
    end

    // Holding data is qualified by hold_v_q, so it needs no reset.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
        tmds_shift_lane #(
            .SYM_W (SYM_W)
        ) u_lane (
            .clk_i  (clk),
            .rst_i  (rst),
            .load_i (load),
            .sym_i  (load_data[n*SYM_W +: SYM_W]),
            .bit_o  (ser_out[n])
        );
    end

    assign ser_clk        = ser_clk_q;
    assign sym_start      = sym_start_q;
    assign underflow      = underflow_q;
    assign underflow_seen = underflow_seen_q;

endmodule

// File: tb/tb_tmds_serializer.sv
`timescale 1ns/1ps
module tb_tmds_serializer;

    localparam int         CH   = 3;
    localparam int         SW   = 10;
    localparam logic [9:0] IDLE = 10'b1101010100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [29:0]   s_data = '0;
    logic          s_ready;
    logic [CH-1:0] ser_out;
    logic          ser_clk;
    logic          sym_start;
    logic          underflow;
    logic          underflow_seen;

    int errors = 0;
    int checks = 0;

    tmds_serializer #(.CHANNELS(CH)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .ser_out        (ser_out),
        .ser_clk        (ser_clk),
        .sym_start      (sym_start),
        .underflow      (underflow),
        .underflow_seen (underflow_seen)
    );

    always #5 clk = ~clk;

    // Reference model: m_t counts edges since reset was released; every
    // tenth edge (t mod 10 == 0) starts a new symbol slot filled with the
    // pending group, or with IDLE when nothing is pending.
    int          m_t = -1;
    logic        m_pend_v = 1'b0;
    logic [29:0] m_pend = '0;
    logic [29:0] m_cur = '0;
    logic        m_under = 1'b0;
    logic        m_seen = 1'b0;
    logic        m_xfer;

    always @(posedge clk) begin
        if (rst) begin
            m_t      = -1;
            m_pend_v = 1'b0;
            m_under  = 1'b0;
            m_seen   = 1'b0;
            m_cur    = '0;
        end else begin
            m_xfer = s_valid && (!m_pend_v || ((m_t + 1) % 10 == 0));
            m_seen = m_seen | m_under;
            m_t    = m_t + 1;
            if (m_t % 10 == 0) begin
                m_under  = !m_pend_v;
                m_cur    = m_pend_v ? m_pend : {CH{IDLE}};
                m_pend_v = 1'b0;
            end else begin
                m_under = 1'b0;
            end
            if (m_xfer) begin
                m_pend_v = 1'b1;
                m_pend   = s_data;
            end
        end
    end

    // Expected {ser_out, ser_clk, sym_start, underflow, underflow_seen, s_ready}.
    function automatic logic [7:0] exp_vec();
        int            ph;
        logic [CH-1:0] so;
        logic          rdy;
        rdy = !rst && (!m_pend_v || ((m_t + 1) % 10 == 0));
        if (m_t < 0) return {7'b0, rdy};
        ph = m_t % 10;
        for (int n = 0; n < CH; n++) so[n] = m_cur[n*SW + ph];
        return {so, (ph < 5), (ph == 0), m_under, m_seen, rdy};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {ser_out, ser_clk, sym_start, underflow, underflow_seen, s_ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until the model says bit 'ph' is on the wire.
    task automatic align(input int ph);
        for (int i = 0; i < 12; i++) begin
            if (m_t >= 0 && m_t % 10 == ph) break;
            tick();
        end
    endtask

    task automatic test_reset();
        int idle_seq[10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 1};
        int uf_cnt;
        uf_cnt  = 0;
        rst     = 1'b1;
        s_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (obs_vec() !== 8'b0) begin
            errors++;
            $display("FAIL reset_values: got %b want %b", obs_vec(), 8'b0);
        end
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle_model c=%0d: got %b want %b", c, obs_vec(), exp_vec());
            end
            checks++;
            if (ser_out[0] !== idle_seq[c % 10][0]) begin
                errors++;
                $display("FAIL reset_idle_bit c=%0d: got %b want %0d", c, ser_out[0], idle_seq[c % 10]);
            end
            if (underflow === 1'b1) uf_cnt++;
        end
        checks++;
        if (uf_cnt != 3) begin
            errors++;
            $display("FAIL reset_underflow_count: got %0d want 3", uf_cnt);
        end
        checks++;
        if (underflow_seen !== 1'b1) begin
            errors++;
            $display("FAIL reset_underflow_seen: got %b want 1", underflow_seen);
        end
    endtask

    task automatic test_single();
        logic [29:0] acc;
        int          lat;
        acc     = '0;
        s_valid = 1'b0;
        align(3);
        s_valid = 1'b1;
        s_data  = {10'h155, 10'h000, 10'h3FF};
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b want 1", s_ready);
        end
        tick();
        s_valid = 1'b0;
        lat = 1;
        while (sym_start !== 1'b1 && lat < 12) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_model: got %b want %b", obs_vec(), exp_vec());
            end
            tick();
            lat++;
        end
        checks++;
        if (lat != 7) begin
            errors++;
            $display("FAIL single_latency: got %0d want 7", lat);
        end
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL single_underflow: got %b want 0", underflow);
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_model k=%0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            for (int n = 0; n < CH; n++) acc[n*SW + k] = ser_out[n];
            tick();
        end
        checks++;
        if (acc[9:0] !== 10'h3FF) begin
            errors++;
            $display("FAIL single_lane0: got %h want 3ff", acc[9:0]);
        end
        checks++;
        if (acc[19:10] !== 10'h000) begin
            errors++;
            $display("FAIL single_lane1: got %h want 000", acc[19:10]);
        end
        checks++;
        if (acc[29:20] !== 10'h155) begin
            errors++;
            $display("FAIL single_lane2: got %h want 155", acc[29:20]);
        end
    endtask

    task automatic test_stream();
        logic [29:0] sent[$];
        int          xc[$];
        logic [29:0] acc;
        logic [29:0] exp_sym;
        int          bitpos;
        int          got;
        logic        sym_uf;
        logic        did;
        bitpos  = -1;
        got     = 0;
        sym_uf  = 1'b0;
        acc     = '0;
        s_valid = 1'b1;
        s_data  = 30'($urandom);
        for (int cyc = 0; cyc < 150; cyc++) begin
            if (cyc == 100) s_valid = 1'b0;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stream_model cyc=%0d: got %b want %b", cyc, obs_vec(), exp_vec());
            end
            if (sym_start === 1'b1) begin
                bitpos = 0;
                sym_uf = underflow;
                if (got > 0 && sent.size() > 0) begin
                    checks++;
                    if (underflow !== 1'b0) begin
                        errors++;
                        $display("FAIL stream_underflow cyc=%0d: got %b want 0", cyc, underflow);
                    end
                end
            end
            if (bitpos >= 0) begin
                for (int n = 0; n < CH; n++) acc[n*SW + bitpos] = ser_out[n];
                bitpos++;
                if (bitpos == 10) begin
                    bitpos = -1;
                    if (sent.size() > 0 && !(sym_uf && got == 0)) begin
                        exp_sym = sent.pop_front();
                        checks++;
                        if (acc !== exp_sym) begin
                            errors++;
                            $display("FAIL stream_symbol #%0d: got %h want %h", got, acc, exp_sym);
                        end
                        got++;
                    end
                end
            end
            did = s_valid && s_ready;
            if (did) begin
                sent.push_back(s_data);
                xc.push_back(cyc);
            end
            tick();
            if (did) s_data = s_data + 30'd1;
        end
        checks++;
        if (sent.size() != 0) begin
            errors++;
            $display("FAIL stream_drain: got %0d left want 0", sent.size());
        end
        checks++;
        if (got != xc.size() || got < 10) begin
            errors++;
            $display("FAIL stream_count: got %0d emitted want %0d (>=10)", got, xc.size());
        end
        for (int i = 2; i < xc.size(); i++) begin
            checks++;
            if (xc[i] - xc[i-1] != 10) begin
                errors++;
                $display("FAIL stream_rate i=%0d: got %0d want 10", i, xc[i] - xc[i-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [29:0] a;
        logic [29:0] b;
        logic [29:0] acc;
        a   = 30'($urandom);
        b   = 30'($urandom);
        acc = '0;
        s_valid = 1'b0;
        align(2);
        s_valid = 1'b1;
        s_data  = a;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_ready: got %b want 1", s_ready);
        end
        tick();
        s_data = b;
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (s_ready !== (k == 6)) begin
                errors++;
                $display("FAIL bp_ready k=%0d: got %b want %b", k, s_ready, (k == 6));
            end
            tick();
        end
        s_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bp_model k=%0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            if (k % 10 == 0) begin
                checks++;
                if (sym_start !== 1'b1 || underflow !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_start k=%0d: got start=%b uf=%b want start=1 uf=0", k, sym_start, underflow);
                end
            end
            for (int n = 0; n < CH; n++) acc[n*SW + (k % 10)] = ser_out[n];
            if (k == 9) begin
                checks++;
                if (acc !== a) begin
                    errors++;
                    $display("FAIL bp_first_symbol: got %h want %h", acc, a);
                end
            end
            if (k == 19) begin
                checks++;
                if (acc !== b) begin
                    errors++;
                    $display("FAIL bp_second_symbol: got %h want %h", acc, b);
                end
            end
            tick();
        end
    endtask

    task automatic test_clock();
        int   since;
        int   hi;
        logic prev;
        since = -1;
        hi    = 0;
        repeat (3) tick();
        prev = ser_clk;
        tick();
        for (int c = 0; c < 40; c++) begin
            s_valid = 1'($urandom);
            s_data  = 30'($urandom);
            if (sym_start === 1'b1) since = 0;
            checks++;
            if (sym_start !== (ser_clk && !prev)) begin
                errors++;
                $display("FAIL clk_rise c=%0d: got start=%b clk=%b prev=%b", c, sym_start, ser_clk, prev);
            end
            if (since >= 0) begin
                checks++;
                if (ser_clk !== (since < 5)) begin
                    errors++;
                    $display("FAIL clk_level since=%0d: got %b want %b", since, ser_clk, (since < 5));
                end
            end
            if (ser_clk === 1'b1) hi++;
            prev = ser_clk;
            tick();
            if (since >= 0) since++;
        end
        s_valid = 1'b0;
        checks++;
        if (hi != 20) begin
            errors++;
            $display("FAIL clk_duty: got %0d high want 20", hi);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_model c=%0d: got %b want %b", c, obs_vec(), exp_vec());
            end
            s_valid = ($urandom % 4) != 0;
            s_data  = 30'($urandom);
            rst     = ($urandom % 80) == 0;
            tick();
        end
        rst     = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic test_midreset();
        logic [29:0] acc;
        acc     = '0;
        s_valid = 1'b0;
        repeat (20) tick();
        align(5);
        s_valid = 1'b1;
        s_data  = 30'h2AB_CDEF;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready: got %b want 1", s_ready);
        end
        tick();
        s_valid = 1'b0;
        rst     = 1'b1;
        tick();
        checks++;
        if (obs_vec() !== 8'b0) begin
            errors++;
            $display("FAIL midrst_values: got %b want %b", obs_vec(), 8'b0);
        end
        rst = 1'b0;
        tick();
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midrst_model k=%0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            if (k % 10 == 0) begin
                checks++;
                if (sym_start !== 1'b1 || underflow !== 1'b1) begin
                    errors++;
                    $display("FAIL midrst_idle_start k=%0d: got start=%b uf=%b want 1 1", k, sym_start, underflow);
                end
            end
            for (int n = 0; n < CH; n++) acc[n*SW + (k % 10)] = ser_out[n];
            if (k % 10 == 9) begin
                checks++;
                if (acc !== {CH{IDLE}}) begin
                    errors++;
                    $display("FAIL midrst_symbol k=%0d: got %h want %h", k, acc, {CH{IDLE}});
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_clock();
        test_random();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
